irq_pending_controller: RTL and testbench

- Sequential front end for the 8-to-3 priority encoding stage.
- Synchronizes 8 asynchronous request lines, captures them into a sticky pending register, and applies a mask.
- Selects the highest-index unmasked pending request (bit 7 highest, bit 0 lowest) and presents its 3-bit ID on a valid/ack handshake to the downstream servicing logic.
- Clears the serviced pending bit on acknowledge.

---
 rtl/irq_pending_controller.sv | 142 ++++++++++++++
 tb/tb_irq_pending_controller.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_controller.sv
// Synchronized 8-line interrupt front end: sticky/level pending capture, masking,
// highest-index selection and a valid/ack handshake. Optional IRQ_OVERRUN_CNT_EN adds overrun_cnt.
module irq_pending_controller #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_MODE   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq_in,
  input  logic [7:0] mask,
  input  logic       irq_ack,
  output logic       irq_valid,
  output logic [2:0] irq_id,
  output logic [7:0] pending,
  output logic       busy
`ifdef IRQ_OVERRUN_CNT_EN
  ,
  output logic [7:0] overrun_cnt
`endif
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRESENT = 2'd1;
  localparam logic [1:0] GAP     = 2'd2;

  logic [SYNC_STAGES-1:0][7:0] sync_reg;
  logic [7:0] s_d_reg;
  logic [7:0] pending_reg;
  logic [1:0] state_reg;
  logic       valid_reg;
  logic [2:0] id_reg;

  logic [7:0] s;
  logic [7:0] rise;
  logic [7:0] clr;
  logic [7:0] eligible;
  logic [2:0] sel_id;
  logic       ack_accept;
  logic [7:0] pending_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
      s_d_reg  <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], irq_in};
      s_d_reg  <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign s          = sync_reg[SYNC_STAGES-1];
  assign rise       = s & ~s_d_reg;
  assign ack_accept = (state_reg == PRESENT) && irq_ack;
  assign eligible   = pending_reg & ~mask;

  always_comb begin
    clr = '0;
    if (EDGE_MODE && ack_accept) clr[id_reg] = 1'b1;
  end

  // Set is ORed in after the clear, so an edge coinciding with an ack re-pends the bit.
  always_comb begin
    pending_next = s;
    if (EDGE_MODE) pending_next = (pending_reg & ~clr) | rise;
  end

  // Ascending scan: the last hit is the highest index.
  always_comb begin
    sel_id = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (eligible[i]) sel_id = i[2:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      valid_reg <= 1'b0;
      id_reg    <= 3'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (eligible != 8'h00) begin
            id_reg    <= sel_id;
            valid_reg <= 1'b1;
            state_reg <= PRESENT;
          end else begin
            valid_reg <= 1'b0;
          end
        end
        PRESENT: begin
          if (irq_ack) begin
            valid_reg <= 1'b0;
            state_reg <= GAP;
          end
        end
        GAP: begin
          valid_reg <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          valid_reg <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign irq_valid = valid_reg;
  assign irq_id    = id_reg;
  assign pending   = pending_reg;
  assign busy      = (state_reg != IDLE);

`ifdef IRQ_OVERRUN_CNT_EN
  logic [7:0] overrun_reg;
  logic       overrun_hit;

  // Several bits overrunning together are a single event.
  assign overrun_hit = |(rise & pending_reg & ~clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_reg <= '0;
    end else if (!EDGE_MODE || ack_accept) begin
      overrun_reg <= '0;
    end else if (overrun_hit && (overrun_reg != 8'hFF)) begin
      overrun_reg <= overrun_reg + 8'd1;
    end
  end

  assign overrun_cnt = overrun_reg;
`endif

endmodule

// File: tb/tb_irq_pending_controller.sv
// Directed bench for irq_pending_controller with a per-cycle reference model of
// pending capture, selection and handshake.
module tb_irq_pending_controller;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] irq_in = 8'h00;
  logic [7:0] mask = 8'h00;
  logic       irq_ack = 1'b0;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic [7:0] pending;
  logic       busy;
`ifdef IRQ_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt;
`endif

  int tests = 0;
  int fails = 0;

  irq_pending_controller #(.SYNC_STAGES(SYNC), .EDGE_MODE(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .irq_in(irq_in),
    .mask(mask),
    .irq_ack(irq_ack),
    .irq_valid(irq_valid),
    .irq_id(irq_id),
    .pending(pending),
    .busy(busy)
`ifdef IRQ_OVERRUN_CNT_EN
    ,
    .overrun_cnt(overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: input history, sticky pending set, and the presentation as a transaction.
  logic [7:0] m_hist [0:4];
  logic [7:0] m_pending;
  int         m_phase;   // 0 idle, 1 presenting, 2 gap
  logic       m_valid;
  logic [2:0] m_id;

  always @(posedge clk) begin : model
    logic [7:0] sv, sdv, rise, elig, nxt;
    logic found;
    if (rst) begin
      for (int k = 0; k < 5; k++) m_hist[k] = 8'h00;
      m_pending = 8'h00;
      m_phase   = 0;
      m_valid   = 1'b0;
      m_id      = 3'd0;
    end else begin
      sv   = m_hist[SYNC-1];
      sdv  = m_hist[SYNC];
      rise = sv & ~sdv;
      nxt  = m_pending;
      if (m_phase == 1 && irq_ack) nxt[m_id] = 1'b0;
      nxt  = nxt | rise;
      elig = m_pending & ~mask;
      case (m_phase)
        0: if (elig != 8'h00) begin
             found = 1'b0;
             for (int i = 7; i >= 0; i--) begin
               if (!found && elig[i]) begin
                 m_id  = 3'(i);
                 found = 1'b1;
               end
             end
             m_valid = 1'b1;
             m_phase = 1;
           end
        1: if (irq_ack) begin
             m_valid = 1'b0;
             m_phase = 2;
           end
        default: m_phase = 0;
      endcase
      m_pending = nxt;
      for (int k = 4; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = irq_in;
    end
    #1;
    check("model_valid", {31'd0, irq_valid}, {31'd0, m_valid});
    check("model_pending", {24'd0, pending}, {24'd0, m_pending});
    check("model_busy", {31'd0, busy}, {31'd0, m_phase != 0});
    if (m_valid) check("model_id", {29'd0, irq_id}, {29'd0, m_id});
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!irq_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, irq_valid}, 32'd1);
  endtask

  task automatic pulse(input logic [7:0] v);
    irq_in = v;
    cyc(1);
    irq_in = 8'h00;
  endtask

  task automatic ack_once();
    irq_ack = 1'b1;
    cyc(1);
    irq_ack = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    check("reset_pending", {24'd0, pending}, 32'h0);
    check("reset_valid", {31'd0, irq_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    cyc(2);

    // Single pulse on bit 2: latency and clear on ack
    irq_in = 8'h04;
    cyc(1);
    irq_in = 8'h00;
    cyc(2);
    check("lat_pending", {24'd0, pending}, 32'h04);
    check("lat_valid_early", {31'd0, irq_valid}, 32'd0);
    cyc(1);
    check("lat_valid", {31'd0, irq_valid}, 32'd1);
    check("lat_id", {29'd0, irq_id}, 32'd2);
    ack_once();
    check("ack_pending", {24'd0, pending}, 32'h00);
    check("ack_gap_valid", {31'd0, irq_valid}, 32'd0);
    check("ack_gap_busy", {31'd0, busy}, 32'd1);
    cyc(3);

    // Priority 0x81: 7 first, then 0
    pulse(8'h81);
    wait_valid("prio_wait1");
    check("prio_id7", {29'd0, irq_id}, 32'd7);
    ack_once();
    check("prio_gap", {31'd0, irq_valid}, 32'd0);
    wait_valid("prio_wait2");
    check("prio_id0", {29'd0, irq_id}, 32'd0);
    ack_once();
    check("prio_pending0", {24'd0, pending}, 32'h00);
    cyc(3);

    // Masked request stays pending but unpresented
    mask = 8'h20;
    pulse(8'h20);
    cyc(20);
    check("mask_pending", {24'd0, pending}, 32'h20);
    check("mask_valid", {31'd0, irq_valid}, 32'd0);
    mask = 8'h00;
    cyc(2);
    check("unmask_valid", {31'd0, irq_valid}, 32'd1);
    check("unmask_id", {29'd0, irq_id}, 32'd5);
    ack_once();
    cyc(3);

    // Stability of a presented ID
    pulse(8'h08);
    wait_valid("stab_wait");
    check("stab_id3", {29'd0, irq_id}, 32'd3);
    irq_in = 8'h40;
    mask = 8'h08;
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      check("stab_hold_valid", {31'd0, irq_valid}, 32'd1);
      check("stab_hold_id", {29'd0, irq_id}, 32'd3);
    end
    ack_once();
    irq_in = 8'h00;
    wait_valid("stab_wait6");
    check("stab_id6", {29'd0, irq_id}, 32'd6);
    ack_once();
    mask = 8'h00;
    cyc(3);

    // Set wins over clear on bit 1
    pulse(8'h02);
    wait_valid("setwin_wait");
    check("setwin_id1", {29'd0, irq_id}, 32'd1);
    irq_in = 8'h02;
    cyc(1);
    irq_in = 8'h00;
    cyc(SYNC - 1);
    ack_once();
    check("setwin_pending", {24'd0, pending}, 32'h02);
    check("setwin_gap", {31'd0, irq_valid}, 32'd0);
    wait_valid("setwin_wait2");
    check("setwin_id_again", {29'd0, irq_id}, 32'd1);
    ack_once();
    check("setwin_cleared", {24'd0, pending}, 32'h00);
    cyc(3);

`ifdef IRQ_OVERRUN_CNT_EN
    mask = 8'h10;
    for (int k = 0; k < 4; k++) begin
      pulse(8'h10);
      cyc(1);
    end
    cyc(4);
    check("overrun_cnt3", {24'd0, overrun_cnt}, 32'd3);
    mask = 8'h00;
    wait_valid("overrun_wait");
    ack_once();
    check("overrun_clear", {24'd0, overrun_cnt}, 32'd0);
    cyc(3);
`endif

    // Asynchronous reset mid-handshake
    pulse(8'h01);
    wait_valid("arst_wait");
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, irq_valid}, 32'd0);
    check("arst_pending", {24'd0, pending}, 32'h00);
    check("arst_busy", {31'd0, busy}, 32'd0);
    cyc(2);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      check("arst_no_spurious", {31'd0, irq_valid}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
